nf10_output_port_demux: RTL and testbench
=========================================

NF10_OUTPUT_PORT_DEMUX -- requirements
Module: nf10_output_port_demux

Interface
Parameters:
REQ-001 SHALL have C_AXIS_DATA_WIDTH, default 256: tdata width per stream.
REQ-002 SHALL have C_USER_WIDTH, default 128: tuser width.
REQ-003 SHALL have NUM_PORTS, default 8: output stream count (even = MAC, odd = CPU).
REQ-004 SHALL have DST_PORT_POS, default 24: LSB of the one-hot destination mask in tuser.

Ports (W = C_AXIS_DATA_WIDTH, U = C_USER_WIDTH, N = NUM_PORTS):
REQ-005 SHALL have axi_aclk, in, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have axi_reset, in, 1: synchronous, active-high reset.
REQ-007 SHALL have s_axis_tdata in W, s_axis_tstrb in W/8, s_axis_tuser in U, s_axis_tvalid in 1, s_axis_tready out 1, s_axis_tlast in 1: the stream from the output port lookup stage.
REQ-008 SHALL have m_axis_tdata out N*W, m_axis_tstrb out N*W/8, m_axis_tuser out N*U: packed per-port buses, port i at slice i.
REQ-009 SHALL have m_axis_tvalid out N, m_axis_tready in N, m_axis_tlast out N: one bit per port.
REQ-010 SHALL have pkt_fwd_count, out, 32: number of packets forwarded.
REQ-011 SHALL have pkt_drop_count, out, 32: number of packets dropped.

Function
REQ-012 SHALL broadcast s_axis_tdata, tstrb, tuser and tlast unmodified onto every port slice, with zero-cycle combinational latency.
REQ-013 SHALL use a state machine with two states:
  - HEADER: first beat of a packet.
  - PACKET: subsequent beats.
REQ-014 SHALL use, in HEADER, the mask s_axis_tuser[DST_PORT_POS +: N]; tuser bits above the mask are ignored.
REQ-015 SHALL register the HEADER mask into dst_mask when the first beat completes, and use dst_mask in PACKET.
REQ-016 SHALL maintain an N-bit done vector that records which selected ports have already accepted the current beat.
REQ-017 SHALL drive m_axis_tvalid[i] = s_axis_tvalid & mask[i] & ~done[i].
REQ-018 SHALL define beat completion as s_axis_tvalid & (for every i with mask[i]: done[i] | m_axis_tready[i]), for a non-zero mask.
REQ-019 SHALL drive s_axis_tready = (mask==0) | (for every i with mask[i]: done[i] | m_axis_tready[i]).
REQ-020 SHALL, on a cycle with m_axis_tvalid[i] & m_axis_tready[i] and no beat completion, set done[i].
REQ-021 SHALL clear the whole done vector on every beat completion.
REQ-022 SHALL never deassert m_axis_tvalid[i] before port i's handshake, given stable upstream valid (AXI-Stream rule); a slow port stalls only the input, never re-sends to ports already marked done.
REQ-023 SHALL treat a zero mask in HEADER as a drop:
  - s_axis_tready = 1 and all m_axis_tvalid = 0 until the tlast beat.
  - pkt_drop_count increments by 1 on the tlast handshake.
REQ-024 SHALL define transitions as:
  - HEADER -> PACKET on first-beat completion with tlast=0.
  - Any state -> HEADER on a completed tlast beat.
  - A single-beat packet (tlast on the header beat) stays in HEADER.
REQ-025 SHALL increment pkt_fwd_count by 1 on completion of a forwarded tlast beat; a multicast packet counts once.
REQ-026 SHALL let both counters wrap modulo 2^32.
REQ-027 SHALL register dst_mask in PACKET for the packet's duration, so mask changes on s_axis_tuser mid-packet have no effect.
REQ-028 SHALL sustain full throughput: one beat per cycle when all selected ports hold tready=1.

Reset
REQ-029 SHALL, while axi_reset=1 at a clock edge, set state=HEADER, done=0, dst_mask=0, pkt_fwd_count=0 and pkt_drop_count=0.
REQ-030 SHALL, after reset, output m_axis_tvalid=0 whenever s_axis_tvalid=0, and s_axis_tready reflects REQ-019 from the HEADER state.
REQ-031 SHALL abandon a packet when reset is asserted mid-packet; the next beat after reset release is treated as a header beat.

Verification
REQ-032 SHALL cover unicast: 3-beat packet, mask 0x04, all tready=1 -> beats on port 2 only in 3 consecutive cycles; pkt_fwd_count=1.
REQ-033 SHALL cover multicast skew: mask 0x05, port 0 tready=1, port 2 tready=0 for 2 cycles -> port 0 handshakes once (done[0] set, tvalid[0] drops); s_axis_tready=0 for 2 cycles; beat completes when port 2 tready rises; no duplicate on port 0.
REQ-034 SHALL cover drop: 4-beat packet, mask 0x00 -> s_axis_tready=1 for 4 cycles; no m_axis_tvalid; pkt_drop_count=1; pkt_fwd_count unchanged.
REQ-035 SHALL cover back-to-back single-beat packets: masks 0x01 then 0x80 -> port 0 then port 7 in consecutive cycles; state stays HEADER; pkt_fwd_count=2.
REQ-036 SHALL cover mid-packet tuser change: header mask 0x02, beat 2 tuser mask 0x10 -> all beats go to port 1 only.
REQ-037 SHALL cover reset mid-packet: axi_reset pulsed after beat 2 of 5 -> counters=0, state=HEADER; the next beat's tuser mask selects the ports.

Source files
------------

// File: rtl/nf10_output_port_demux.sv
// Output port demultiplexer: broadcasts one AXI-Stream input onto NUM_PORTS
// output slices. A one-hot (or multi-hot) mask in tuser selects the ports
// that receive each packet, and a zero mask drops the packet. The mask is
// captured on the header beat and held for the rest of the packet.
module nf10_output_port_demux #(
    parameter int C_AXIS_DATA_WIDTH = 256,
    parameter int C_USER_WIDTH      = 128,
    parameter int NUM_PORTS         = 8,
    parameter int DST_PORT_POS      = 24
) (
    input  logic                                     axi_aclk,
    input  logic                                     axi_reset,

    input  logic [C_AXIS_DATA_WIDTH-1:0]             s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]           s_axis_tstrb,
    input  logic [C_USER_WIDTH-1:0]                  s_axis_tuser,
    input  logic                                     s_axis_tvalid,
    output logic                                     s_axis_tready,
    input  logic                                     s_axis_tlast,

    output logic [NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [NUM_PORTS*C_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic [NUM_PORTS*C_USER_WIDTH-1:0]        m_axis_tuser,
    output logic [NUM_PORTS-1:0]                     m_axis_tvalid,
    input  logic [NUM_PORTS-1:0]                     m_axis_tready,
    output logic [NUM_PORTS-1:0]                     m_axis_tlast,

    output logic [31:0]                              pkt_fwd_count,
    output logic [31:0]                              pkt_drop_count
);

    localparam logic HEADER = 1'b0;
    localparam logic PACKET = 1'b1;

    logic                 state_q, state_d;
    logic [NUM_PORTS-1:0] dst_mask_q, dst_mask_d;
    logic [NUM_PORTS-1:0] done_q, done_d;
    logic [31:0]          fwd_q, fwd_d;
    logic [31:0]          drop_q, drop_d;

    logic [NUM_PORTS-1:0] mask;
    logic                 all_ok;
    logic                 xfer;

    // Payload is shared by every port; only tvalid is per-port.
    assign m_axis_tdata = {NUM_PORTS{s_axis_tdata}};
    assign m_axis_tstrb = {NUM_PORTS{s_axis_tstrb}};
    assign m_axis_tuser = {NUM_PORTS{s_axis_tuser}};
    assign m_axis_tlast = {NUM_PORTS{s_axis_tlast}};

    // Header beats steer from live tuser; later beats use the captured mask.
    assign mask = (state_q == HEADER) ? s_axis_tuser[DST_PORT_POS +: NUM_PORTS] : dst_mask_q;

    // Every selected port has either taken the beat already or takes it now.
    assign all_ok = &(~mask | done_q | m_axis_tready);

    // A zero mask means drop: accept unconditionally, present to nobody.
    assign s_axis_tready = (mask == '0) | all_ok;
    assign m_axis_tvalid = {NUM_PORTS{s_axis_tvalid}} & mask & ~done_q;
    assign xfer          = s_axis_tvalid & s_axis_tready;

    assign pkt_fwd_count  = fwd_q;
    assign pkt_drop_count = drop_q;

    // Next-state: packet framing, per-beat delivery tracking and counters.
    always_comb begin
        state_d    = state_q;
        dst_mask_d = dst_mask_q;
        fwd_d      = fwd_q;
        drop_d     = drop_q;
        done_d     = done_q;
        if (xfer) begin
            // Beat fully delivered: start the next one with a clean slate.
            done_d = '0;
            if (state_q == HEADER) begin
                dst_mask_d = mask;
            end
            if (s_axis_tlast) begin
                state_d = HEADER;
                if (mask == '0) begin
                    drop_d = drop_q + 32'd1;
                end else begin
                    fwd_d = fwd_q + 32'd1;
                end
            end else begin
                state_d = PACKET;
            end
        end else begin
            // Remember early takers so they are not offered the beat twice.
            done_d = done_q | (m_axis_tvalid & m_axis_tready);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state_q    <= HEADER;
            dst_mask_q <= '0;
            done_q     <= '0;
            fwd_q      <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            dst_mask_q <= dst_mask_d;
            done_q     <= done_d;
            fwd_q      <= fwd_d;
            drop_q     <= drop_d;
        end
    end

endmodule

// File: tb/tb_nf10_output_port_demux.sv
// Bench for nf10_output_port_demux: directed scenarios followed by random
// packets and random per-port backpressure, checked against a packet-level
// reference model that tracks what each port should receive.
module tb_nf10_output_port_demux;

    localparam int W   = 64;
    localparam int U   = 128;
    localparam int NP  = 8;
    localparam int POS = 24;

    logic              clk = 1'b0;
    logic              axi_reset;
    logic [W-1:0]      s_axis_tdata;
    logic [W/8-1:0]    s_axis_tstrb;
    logic [U-1:0]      s_axis_tuser;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic              s_axis_tlast;
    logic [NP*W-1:0]   m_axis_tdata;
    logic [NP*W/8-1:0] m_axis_tstrb;
    logic [NP*U-1:0]   m_axis_tuser;
    logic [NP-1:0]     m_axis_tvalid;
    logic [NP-1:0]     m_axis_tready;
    logic [NP-1:0]     m_axis_tlast;
    logic [31:0]       pkt_fwd_count;
    logic [31:0]       pkt_drop_count;

    always #5 clk = ~clk;

    nf10_output_port_demux #(
        .C_AXIS_DATA_WIDTH(W),
        .C_USER_WIDTH     (U),
        .NUM_PORTS        (NP),
        .DST_PORT_POS     (POS)
    ) dut (
        .axi_aclk      (clk),
        .axi_reset     (axi_reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tstrb  (s_axis_tstrb),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .pkt_fwd_count (pkt_fwd_count),
        .pkt_drop_count(pkt_drop_count)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: packet mask is fixed by the first accepted beat of a
    // packet; every accepted beat is owed once to each port in that mask.
    bit            in_pkt;
    logic [NP-1:0] pkt_mask;
    logic [NP-1:0] mm;
    logic [NP-1:0] pend;
    int unsigned   exp_fwd, exp_drop;
    logic [W:0]    expq [NP][$];
    logic [W:0]    gotq [NP][$];
    bit            rdy_rand = 1'b0;

    always @(negedge clk) begin
        if (axi_reset) begin
            in_pkt   = 1'b0;
            exp_fwd  = 0;
            exp_drop = 0;
            pend     = '0;
            for (int i = 0; i < NP; i++) begin
                expq[i].delete();
                gotq[i].delete();
            end
        end else begin
            for (int i = 0; i < NP; i++) begin
                if (pend[i]) chk($sformatf("hold_p%0d", i), m_axis_tvalid[i], 1'b1);
                if (m_axis_tvalid[i] && m_axis_tready[i])
                    gotq[i].push_back({m_axis_tlast[i], m_axis_tdata[i*W +: W]});
            end
            pend = m_axis_tvalid & ~m_axis_tready;
            if (s_axis_tvalid && (&m_axis_tready)) chk("thruput", s_axis_tready, 1'b1);
            if (s_axis_tvalid && s_axis_tready) begin
                mm = in_pkt ? pkt_mask : s_axis_tuser[POS +: NP];
                if (!in_pkt) pkt_mask = mm;
                for (int i = 0; i < NP; i++)
                    if (mm[i]) expq[i].push_back({s_axis_tlast, s_axis_tdata});
                if (s_axis_tlast) begin
                    if (mm == '0) exp_drop++;
                    else exp_fwd++;
                    in_pkt = 1'b0;
                end else begin
                    in_pkt = 1'b1;
                end
            end
        end
    end

    // Random backpressure, one independent coin per port, biased towards ready.
    initial begin
        logic [NP-1:0] r;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) begin
                for (int b = 0; b < NP; b++) r[b] = ($urandom_range(0, 3) != 0);
                m_axis_tready = r;
            end
        end
    end

    task automatic set_beat(input logic [NP-1:0] umask, input bit last);
        s_axis_tdata  = {$urandom, $urandom};
        s_axis_tstrb  = 8'($urandom);
        s_axis_tuser  = {$urandom, $urandom, $urandom, $urandom};
        s_axis_tuser[POS +: NP] = umask;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
    endtask

    task automatic send_beat(input logic [NP-1:0] umask, input bit last,
                             input bit vchk, input logic [NP-1:0] exp_v, output int cyc);
        set_beat(umask, last);
        cyc = 0;
        forever begin
            @(negedge clk);
            if (vchk && cyc == 0) chk("tvalid", m_axis_tvalid, exp_v);
            cyc++;
            if (s_axis_tready) break;
            if (cyc > 200) begin
                $display("FAIL timeout: no input handshake after %0d cycles", cyc);
                $fatal(1);
            end
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic check_queues(input string tag);
        for (int i = 0; i < NP; i++) begin
            chk($sformatf("%s_cnt_p%0d", tag, i), gotq[i].size(), expq[i].size());
            for (int j = 0; j < gotq[i].size() && j < expq[i].size(); j++)
                chk($sformatf("%s_beat_p%0d_%0d", tag, i, j), gotq[i][j], expq[i][j]);
            gotq[i].delete();
            expq[i].delete();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        int len;
        logic [NP-1:0] pm;

        axi_reset     = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tstrb  = '0;
        s_axis_tuser  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = '0;
        repeat (3) tick();
        axi_reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tready", s_axis_tready, 1);
        chk("rst_fwd", pkt_fwd_count, 0);
        chk("rst_drop", pkt_drop_count, 0);
        tick();

        // Unicast, 3 beats to port 2, full rate
        m_axis_tready = '1;
        for (int b = 0; b < 3; b++) begin
            send_beat(8'h04, b == 2, 1'b1, 8'h04, cyc);
            chk("uni_cycles", cyc, 1);
        end
        check_queues("uni");
        chk("uni_fwd", pkt_fwd_count, 1);

        // Multicast with port 2 stalled for two cycles
        m_axis_tready = 8'h01;
        set_beat(8'h05, 1'b1);
        @(negedge clk);
        chk("mc_v0", m_axis_tvalid, 8'h05);
        chk("mc_r0", s_axis_tready, 0);
        tick();
        @(negedge clk);
        chk("mc_v1", m_axis_tvalid, 8'h04);
        chk("mc_r1", s_axis_tready, 0);
        tick();
        m_axis_tready = 8'h05;
        @(negedge clk);
        chk("mc_v2", m_axis_tvalid, 8'h04);
        chk("mc_r2", s_axis_tready, 1);
        tick();
        s_axis_tvalid = 1'b0;
        check_queues("mc");
        chk("mc_fwd", pkt_fwd_count, 2);

        // Drop: zero header mask, later beats carry non-zero masks, no ready
        m_axis_tready = '0;
        for (int b = 0; b < 4; b++) begin
            send_beat((b == 0) ? 8'h00 : 8'hff, b == 3, 1'b1, 8'h00, cyc);
            chk("drop_cycles", cyc, 1);
        end
        check_queues("drop");
        chk("drop_drop", pkt_drop_count, 1);
        chk("drop_fwd", pkt_fwd_count, 2);

        // Back-to-back single-beat packets
        m_axis_tready = '1;
        send_beat(8'h01, 1'b1, 1'b1, 8'h01, cyc);
        chk("b2b_cyc0", cyc, 1);
        send_beat(8'h80, 1'b1, 1'b1, 8'h80, cyc);
        chk("b2b_cyc1", cyc, 1);
        check_queues("b2b");
        chk("b2b_fwd", pkt_fwd_count, 4);

        // Mid-packet tuser mask change is ignored
        send_beat(8'h02, 1'b0, 1'b1, 8'h02, cyc);
        send_beat(8'h10, 1'b0, 1'b1, 8'h02, cyc);
        send_beat(8'h40, 1'b1, 1'b1, 8'h02, cyc);
        check_queues("midmask");
        chk("midmask_fwd", pkt_fwd_count, 5);

        // Reset after beat 2 of 5 abandons the packet
        send_beat(8'h08, 1'b0, 1'b1, 8'h08, cyc);
        send_beat(8'h08, 1'b0, 1'b1, 8'h08, cyc);
        axi_reset = 1'b1;
        tick();
        axi_reset = 1'b0;
        @(negedge clk);
        chk("rstmid_fwd", pkt_fwd_count, 0);
        chk("rstmid_drop", pkt_drop_count, 0);
        tick();
        send_beat(8'h20, 1'b0, 1'b1, 8'h20, cyc);
        send_beat(8'h01, 1'b1, 1'b1, 8'h20, cyc);
        check_queues("rstmid");
        chk("rstmid_fwd2", pkt_fwd_count, 1);

        // Random packets, masks and backpressure
        rdy_rand = 1'b1;
        for (int p = 0; p < 150; p++) begin
            len = $urandom_range(1, 6);
            pm  = ($urandom_range(0, 6) == 0) ? 8'h00 : 8'($urandom);
            for (int b = 0; b < len; b++) begin
                send_beat((b == 0) ? pm : 8'($urandom), b == len - 1, 1'b0, 8'h00, cyc);
                if ($urandom_range(0, 3) == 0) tick();
            end
        end
        rdy_rand = 1'b0;
        repeat (2) tick();
        check_queues("rand");
        chk("rand_fwd", pkt_fwd_count, exp_fwd);
        chk("rand_drop", pkt_drop_count, exp_drop);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
